// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
// Module   : route_pkg
// Purpose  : Shared one-hot output-port codes and route FSM state encoding
//            for the router input-channel route computation logic.
// Revision : 1.0 - initial release
// ============================================================================
package route_pkg;

    // One-hot output port codes, bit0 = EAST
    localparam logic [4:0] P_EAST  = 5'b00001;
    localparam logic [4:0] P_WEST  = 5'b00010;
    localparam logic [4:0] P_NORTH = 5'b00100;
    localparam logic [4:0] P_SOUTH = 5'b01000;
    localparam logic [4:0] P_LOCAL = 5'b10000;

    // Route compute FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } route_state_t;

endpackage
`default_nettype wire

// File: rtl/xy_route_decode.sv
`default_nettype none
// ============================================================================
// Module   : xy_route_decode
// Purpose  : Combinational dimension-order (X then Y) route decode from the
//            destination coordinates to a one-hot output port.
// Revision : 1.0 - initial release
// ============================================================================
module xy_route_decode
    import route_pkg::*;
#(
    parameter int COORD_BITS = 2,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0
) (
    input  logic [COORD_BITS-1:0] dest_x,
    input  logic [COORD_BITS-1:0] dest_y,
    output logic [4:0]            port
);

    localparam logic [COORD_BITS-1:0] C_LOCAL_X = COORD_BITS'(LOCAL_X);
    localparam logic [COORD_BITS-1:0] C_LOCAL_Y = COORD_BITS'(LOCAL_Y);

    // X is resolved fully before Y; the final else guarantees one-hot output
    always_comb begin
        port = P_LOCAL;
        if (dest_x > C_LOCAL_X) begin
            port = P_EAST;
        end else if (dest_x < C_LOCAL_X) begin
            port = P_WEST;
        end else if (dest_y < C_LOCAL_Y) begin
            port = P_NORTH;
        end else if (dest_y > C_LOCAL_Y) begin
            port = P_SOUTH;
        end else begin
            port = P_LOCAL;
        end
    end

endmodule
`default_nettype wire

// File: rtl/route_compute_unit.sv
`default_nettype none
// ============================================================================
// Module   : route_compute_unit
// Purpose  : Pops flits from one router input FIFO, computes the XY output
//            port and holds flit + port under a valid/ready handshake.
//            Optional macro ROUTE_STATS_EN adds a saturating 16-bit
//            routed-flit counter on port flit_count.
// Revision : 1.0 - initial release
// ============================================================================
module route_compute_unit
    import route_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int COORD_BITS = 2,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    input  logic [NUM_BITS-1:0] fifo_data,
    output logic                fifo_rd_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_flit,
    output logic [4:0]          out_port
`ifdef ROUTE_STATS_EN
    ,
    output logic [15:0]         flit_count
`endif
);

    route_state_t        r_state;
    route_state_t        w_next_state;
    logic                w_rd_en;
    logic                w_load;
    logic                w_clear;
    logic [4:0]          w_port;
    logic                r_out_valid;
    logic [NUM_BITS-1:0] r_out_flit;
    logic [4:0]          r_out_port;

    xy_route_decode #(
        .COORD_BITS (COORD_BITS),
        .LOCAL_X    (LOCAL_X),
        .LOCAL_Y    (LOCAL_Y)
    ) u_decode (
        .dest_x (fifo_data[NUM_BITS-1 -: COORD_BITS]),
        .dest_y (fifo_data[NUM_BITS-1-COORD_BITS -: COORD_BITS]),
        .port   (w_port)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, pop request and output-register control
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_rd_en      = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_load       = 1'b1;
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_clear = 1'b1;
                    if (!fifo_empty) begin
                        w_rd_en      = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Gate with rst_n so no pop escapes while the FIFO itself is in reset
    assign fifo_rd_en = w_rd_en & rst_n;

    // Output register: capture in FETCH, release on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_port  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_flit  <= fifo_data;
            r_out_port  <= w_port;
        end else if (w_clear) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_port  = r_out_port;

`ifdef ROUTE_STATS_EN
    logic [15:0] r_flit_count;

    // Saturating count of completed downstream handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_count <= '0;
        end else if (r_out_valid && out_ready && (r_flit_count != 16'hFFFF)) begin
            r_flit_count <= r_flit_count + 16'd1;
        end
    end

    assign flit_count = r_flit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_route_compute_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_route_compute_unit
// Purpose  : Directed self-checking bench for route_compute_unit with a
//            behavioural registered-output FIFO in front of the DUT.
//            Define ROUTE_STATS_EN to also exercise flit_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_route_compute_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_flit;
    logic [4:0] out_port;
`ifdef ROUTE_STATS_EN
    logic [15:0] flit_count;
`endif

    route_compute_unit #(
        .NUM_BITS   (8),
        .COORD_BITS (2),
        .LOCAL_X    (1),
        .LOCAL_Y    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flit   (out_flit),
        .out_port   (out_port)
`ifdef ROUTE_STATS_EN
        ,
        .flit_count (flit_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered output, cleared by the same rst_n
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= wr_ptr;
            fifo_data <= 8'h00;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Monitor, sampled on the falling edge
    int         cyc = 0;
    int         hs_cnt = 0;
    int         rd_cnt = 0;
    int         valid_cnt = 0;
    int         rd_empty_viol = 0;
    int         bad_onehot = 0;
    int         last_pop = 0;
    int         rise_cyc = 0;
    logic       prev_v = 1'b0;
    logic [7:0] rx_flit [64];
    logic [4:0] rx_port [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt   <= rd_cnt + 1;
            last_pop <= cyc;
            if (fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
        end
        if (out_valid) begin
            valid_cnt <= valid_cnt + 1;
            if (!prev_v) rise_cyc <= cyc;
            if (!$onehot(out_port)) bad_onehot <= bad_onehot + 1;
        end
        if (out_valid && out_ready) begin
            rx_flit[hs_cnt[5:0]] <= out_flit;
            rx_port[hs_cnt[5:0]] <= out_port;
            hs_cnt <= hs_cnt + 1;
        end
        prev_v <= out_valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic wait_hs(input int n);
        int b = 0;
        while (hs_cnt < n && b < 200) begin
            tick();
            b++;
        end
        check("hs_timeout", 32'(hs_cnt >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int b = 0;
        while (!out_valid && b < 50) begin
            tick();
            b++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    logic [7:0] t1_flit [5] = '{8'hB5, 8'h05, 8'h45, 8'h7F, 8'h55};
    logic [4:0] t1_port [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    logic [7:0] t3_flit [3] = '{8'h3A, 8'hC1, 8'h62};

    initial begin
        int         b;
        int         r0;
        int         v0;
        logic [7:0] f0;
        logic [4:0] p0;
        logic       unstable;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_flit", 32'(out_flit), 32'd0);
        check("rst_port", 32'(out_port), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1. Port decode for all five directions
        b = hs_cnt;
        for (int i = 0; i < 5; i++) push(t1_flit[i]);
        wait_hs(b + 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_flit%0d", i), 32'(rx_flit[b + i]), 32'(t1_flit[i]));
            check($sformatf("t1_port%0d", i), 32'(rx_port[b + i]), 32'(t1_port[i]));
        end
        repeat (3) tick();

        // 2. Latency from pop to out_valid
        r0 = rd_cnt;
        push(8'hB5);
        repeat (6) tick();
        check("t2_pops", 32'(rd_cnt - r0), 32'd1);
        check("t2_latency", 32'(rise_cyc - last_pop), 32'd2);
        check("t2_port", 32'(rx_port[hs_cnt - 1]), 32'(5'b00001));

        // 3. Backpressure
        out_ready = 1'b0;
        b = hs_cnt;
        for (int i = 0; i < 3; i++) push(t3_flit[i]);
        wait_valid();
        r0 = rd_cnt;
        f0 = out_flit;
        p0 = out_port;
        unstable = 1'b0;
        repeat (10) begin
            tick();
            if (out_flit !== f0 || out_port !== p0 || !out_valid) unstable = 1'b1;
        end
        check("t3_stable", 32'(unstable), 32'd0);
        check("t3_flit0", 32'(f0), 32'(t3_flit[0]));
        check("t3_no_pop", 32'(rd_cnt - r0), 32'd0);
        check("t3_level", 32'(wr_ptr - rd_ptr), 32'd2);
        out_ready = 1'b1;
        wait_hs(b + 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_order%0d", i), 32'(rx_flit[b + i]), 32'(t3_flit[i]));
        repeat (3) tick();

        // 4. Empty guard
        r0 = rd_cnt;
        v0 = valid_cnt;
        b = hs_cnt;
        repeat (20) tick();
        check("t4_no_pop", 32'(rd_cnt - r0), 32'd0);
        check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
        push(8'h55);
        repeat (10) tick();
        check("t4_one_hs", 32'(hs_cnt - b), 32'd1);
        check("t4_flit", 32'(rx_flit[b]), 32'h55);

        // 5. Reset mid-HOLD
        out_ready = 1'b0;
        push(8'hB5);
        push(8'h05);
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_flit", 32'(out_flit), 32'd0);
        check("t5_port", 32'(out_port), 32'd0);
        check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef ROUTE_STATS_EN
        check("t5_count", 32'(flit_count), 32'd0);
`endif
        push(8'h7F);
        #1;
        check("t5_rd_en_nonempty", 32'(fifo_rd_en), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        v0 = valid_cnt;
        b = hs_cnt;
        repeat (8) tick();
        check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t5_no_hs", 32'(hs_cnt - b), 32'd0);

`ifdef ROUTE_STATS_EN
        // 6. Routed-flit counter and saturation
        check("t6_zero", 32'(flit_count), 32'd0);
        b = hs_cnt;
        for (int i = 0; i < 5; i++) push(t1_flit[i]);
        wait_hs(b + 5);
        tick();
        check("t6_five", 32'(flit_count), 32'd5);
        force dut.r_flit_count = 16'hFFFE;
        tick();
        release dut.r_flit_count;
        tick();
        check("t6_forced", 32'(flit_count), 32'hFFFE);
        b = hs_cnt;
        for (int i = 0; i < 3; i++) push(t1_flit[i]);
        wait_hs(b + 3);
        tick();
        check("t6_saturate", 32'(flit_count), 32'hFFFF);
`endif

        check("rd_en_when_empty", 32'(rd_empty_viol), 32'd0);
        check("port_onehot", 32'(bad_onehot), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
